nibble_serial_adder: RTL and testbench

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

---
 rtl/nibble_serial_adder.sv | 184 ++++++++++++++++++
 tb/tb_nibble_serial_adder.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Adds two W-bit operands (W = 4*N_NIBBLES) plus a carry-in by reusing a
//   single 4-bit carry-select adder once per clock. Nibbles are processed
//   LSB first. The result appears N_NIBBLES cycles after start is accepted.
//
// Ports
//   clk    in   system clock, all state updates on its rising edge
//   rst_n  in   synchronous active-low reset
//   start  in   begin an addition (sampled only in IDLE)
//   a, b   in   W-bit operands, latched when start is accepted
//   c_in   in   carry into bit 0, latched when start is accepted
//   sum    out  W-bit result register (completed low nibbles during ADD)
//   c_out  out  carry out of bit W-1 (valid from done onward)
//   ovf    out  two's-complement overflow flag (valid from done onward)
//   busy   out  high while the addition is in progress
//   done   out  one-cycle pulse marking the result valid

// carry_select_adder
//   4-bit adder: the low 2-bit half ripples, the high 2-bit half is computed
//   for both possible carries and the low half's carry picks one.
//   Ports: a, b (4-bit operands), c_in, sum (4-bit), c_out.
module carry_select_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    output logic [3:0] sum,
    output logic       c_out
);
    logic [2:0] lo;
    logic [2:0] hi_c0;
    logic [2:0] hi_c1;

    assign lo    = {1'b0, a[1:0]} + {1'b0, b[1:0]} + {2'b00, c_in};
    assign hi_c0 = {1'b0, a[3:2]} + {1'b0, b[3:2]};
    assign hi_c1 = {1'b0, a[3:2]} + {1'b0, b[3:2]} + 3'd1;

    assign sum   = {(lo[2] ? hi_c1[1:0] : hi_c0[1:0]), lo[1:0]};
    assign c_out = lo[2] ? hi_c1[2] : hi_c0[2];
endmodule

module nibble_serial_adder #(
    parameter int N_NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [4*N_NIBBLES-1:0] a,
    input  logic [4*N_NIBBLES-1:0] b,
    input  logic                   c_in,
    output logic [4*N_NIBBLES-1:0] sum,
    output logic                   c_out,
    output logic                   ovf,
    output logic                   busy,
    output logic                   done
);
    localparam int W     = 4 * N_NIBBLES;
    localparam int IDX_W = (N_NIBBLES > 1) ? $clog2(N_NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t           state_reg;
    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;
    logic             carry_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [W-1:0]     sum_reg;
    logic             c_out_reg;
    logic             ovf_reg;
    logic             busy_reg;
    logic             done_reg;

    // Per-nibble views of the latched operands
    logic [3:0] a_nib [N_NIBBLES];
    logic [3:0] b_nib [N_NIBBLES];

    genvar gi;
    generate
        for (gi = 0; gi < N_NIBBLES; gi++) begin : g_nib
            assign a_nib[gi] = a_reg[4*gi +: 4];
            assign b_nib[gi] = b_reg[4*gi +: 4];
        end
    endgenerate

    // Select the nibble pair addressed by idx; explicit compare loop keeps the
    // mux well-defined even when N_NIBBLES is not a power of two.
    logic [3:0] add_a;
    logic [3:0] add_b;
    always_comb begin
        add_a = '0;
        add_b = '0;
        for (int i = 0; i < N_NIBBLES; i++) begin
            if (idx_reg == IDX_W'(i)) begin
                add_a = a_nib[i];
                add_b = b_nib[i];
            end
        end
    end

    logic [3:0] nib_sum;
    logic       nib_carry;

    carry_select_adder u_csa (
        .a     (add_a),
        .b     (add_b),
        .c_in  (carry_reg),
        .sum   (nib_sum),
        .c_out (nib_carry)
    );

    logic last_nibble;
    logic ovf_next;

    assign last_nibble = (idx_reg == IDX_W'(N_NIBBLES - 1));
    // The MSB of the final sum is bit 3 of the nibble being written this cycle.
    assign ovf_next    = (a_reg[W-1] == b_reg[W-1]) && (nib_sum[3] != a_reg[W-1]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            idx_reg   <= '0;
            sum_reg   <= '0;
            c_out_reg <= 1'b0;
            ovf_reg   <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= c_in;
                        idx_reg   <= '0;
                        sum_reg   <= '0;
                        c_out_reg <= 1'b0;
                        ovf_reg   <= 1'b0;
                        busy_reg  <= 1'b1;
                        state_reg <= ADD;
                    end
                end
                ADD: begin
                    for (int i = 0; i < N_NIBBLES; i++) begin
                        if (idx_reg == IDX_W'(i)) begin
                            sum_reg[4*i +: 4] <= nib_sum;
                        end
                    end
                    carry_reg <= nib_carry;
                    if (last_nibble) begin
                        c_out_reg <= nib_carry;
                        ovf_reg   <= ovf_next;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        idx_reg   <= '0;
                        state_reg <= DONE;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                DONE: begin
                    done_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign sum   = sum_reg;
    assign c_out = c_out_reg;
    assign ovf   = ovf_reg;
    assign busy  = busy_reg;
    assign done  = done_reg;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder (default N_NIBBLES = 4, W = 16).
module tb_nibble_serial_adder;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        c_in;
    logic [15:0] sum;
    logic        c_out;
    logic        ovf;
    logic        busy;
    logic        done;

    int vectors;
    int miscompares;

    nibble_serial_adder #(.N_NIBBLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .sum   (sum),
        .c_out (c_out),
        .ovf   (ovf),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full transaction: accept, wait for done (bounded), check result and hold.
    task automatic run(input logic [15:0] ta, input logic [15:0] tb_, input logic tc,
                       input logic [15:0] esum, input logic ecout, input logic eovf);
        int lat;
        a     = ta;
        b     = tb_;
        c_in  = tc;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("accept_busy", {31'd0, busy}, 32'd1);
        check("accept_sum_clear", {16'd0, sum}, 32'd0);
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (done) begin
                lat = i;
                break;
            end
        end
        check("latency", lat, 32'd4);
        check("busy_at_done", {31'd0, busy}, 32'd0);
        check("sum", {16'd0, sum}, {16'd0, esum});
        check("c_out", {31'd0, c_out}, {31'd0, ecout});
        check("ovf", {31'd0, ovf}, {31'd0, eovf});
        tick();
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("sum_hold", {16'd0, sum}, {16'd0, esum});
        $display("vector a=%h b=%h c_in=%0d -> sum=%h c_out=%0d ovf=%0d", ta, tb_, tc, sum, c_out, ovf);
    endtask

    initial begin
        logic [16:0] full;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;
        logic        rovf;

        vectors     = 0;
        miscompares = 0;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        c_in  = 1'b0;

        // Reset held for two cycles
        tick();
        tick();
        check("rst_sum", {16'd0, sum}, 32'd0);
        check("rst_c_out", {31'd0, c_out}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Directed vectors with hand-computed results
        run(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
        run(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        run(16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
        run(16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0, 1'b0);
        run(16'h9999, 16'h6667, 1'b0, 16'h0000, 1'b1, 1'b0);
        run(16'h7000, 16'h1000, 1'b0, 16'h8000, 1'b0, 1'b1);

        // Partial sum after first ADD edge, and start ignored while busy
        a     = 16'h1234;
        b     = 16'h4321;
        c_in  = 1'b1;
        start = 1'b1;
        tick();                       // accept edge
        start = 1'b0;
        tick();                       // first ADD edge
        check("partial_sum", {16'd0, sum}, 32'h0006);
        check("partial_c_out", {31'd0, c_out}, 32'd0);
        check("partial_ovf", {31'd0, ovf}, 32'd0);
        a     = 16'hFFFF;
        start = 1'b1;
        tick();                       // second ADD edge, start must be ignored
        start = 1'b0;
        tick();
        tick();                       // fourth ADD edge -> done
        check("busy_ign_done", {31'd0, done}, 32'd1);
        check("busy_ign_sum", {16'd0, sum}, 32'h5556);
        check("busy_ign_c_out", {31'd0, c_out}, 32'd0);
        check("busy_ign_ovf", {31'd0, ovf}, 32'd0);
        tick();
        check("busy_ign_done_low", {31'd0, done}, 32'd0);
        tick();
        check("busy_ign_no_restart", {31'd0, busy}, 32'd0);
        check("busy_ign_sum_hold", {16'd0, sum}, 32'h5556);
        $display("vector a=1234 b=4321 c_in=1 (start while busy) -> sum=%h", sum);

        // Reset during the second ADD cycle
        a     = 16'h1111;
        b     = 16'h2222;
        c_in  = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_sum", {16'd0, sum}, 32'd0);
        check("midrst_c_out", {31'd0, c_out}, 32'd0);
        check("midrst_ovf", {31'd0, ovf}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("midrst_no_done", {31'd0, done}, 32'd0);
        end
        $display("vector a=1111 b=2222 aborted by reset");
        run(16'h0005, 16'h0003, 1'b0, 16'h0008, 1'b0, 1'b0);

        // Back-to-back random triples against an arithmetic reference
        for (int n = 0; n < 1000; n++) begin
            ra   = 16'($urandom);
            rb   = 16'($urandom);
            rc   = 1'($urandom_range(0, 1));
            full = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
            rovf = (ra[15] == rb[15]) && (full[15] != ra[15]);
            run(ra, rb, rc, full[15:0], full[16], rovf);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
